// File: rtl/sap_ram_loader_if.sv
// ---------------------------------------------------------------------------
// sap_ram_loader_if
// Bundles the program-byte input stream and the RAM write bus of the SAP
// program loader.
//   in_valid / in_data / in_ready : byte stream, transfer when valid & ready
//   ram_we / ram_addr / ram_data  : registered RAM write port
// Modports:
//   slave  : the loader (consumes the stream, drives the RAM bus)
//   master : the environment (produces the stream, observes the RAM bus)
// ---------------------------------------------------------------------------
interface sap_ram_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ram_we,
        output ram_addr,
        output ram_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_data
    );
endinterface

// File: rtl/sap_ram_loader.sv
// ---------------------------------------------------------------------------
// sap_ram_loader
// Loads a DEPTH-word program into the SAP RAM from a byte stream, verifies a
// trailing checksum byte, then clears and releases the CPU until it halts.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   start        : begin a load (honoured only in IDLE, DONE, ERROR)
//   cpu_halt     : CPU decoded HALT (honoured only in RUN)
//   bus          : program byte stream in, RAM write bus out
//   cpu_clear    : one-cycle clear of CPU PC and ring counter
//   cpu_run      : CPU clock enable
//   busy/done/error : status flags
// All outputs are registers; their next values are decoded from next state.
// ---------------------------------------------------------------------------
module sap_ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                cpu_halt,
    sap_ram_loader_if.slave     bus,
    output logic                cpu_clear,
    output logic                cpu_run,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    // Counter value of the last program byte; its handshake ends LOAD.
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    // Modulo-2**DATA_W checksum accumulation.
    function automatic logic [DATA_W-1:0] csum_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_clear_q, cpu_clear_d;
    logic              cpu_run_q, cpu_run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hs_s;
    logic [DATA_W-1:0] check_sum_s;

    // in_ready_q mirrors "state is LOAD or CHECK", so this is the handshake.
    assign hs_s        = bus.in_valid & in_ready_q;
    assign check_sum_s = csum_add(acc_q, bus.in_data);

    // Next-state, counter, accumulator and RAM write-port logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {ADDR_W{1'b0}};
                    acc_d   = {DATA_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cnt_q;
                    ram_data_d = bus.in_data;
                    cnt_d      = cnt_q + ADDR_W'(1);
                    acc_d      = csum_add(acc_q, bus.in_data);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (hs_s) begin
                    if (check_sum_s == {DATA_W{1'b0}}) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status and control outputs decoded from the next state so the registered
    // copies line up with the state register.
    always_comb begin
        in_ready_d  = 1'b0;
        cpu_clear_d = 1'b0;
        cpu_run_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_d)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_CHECK: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_CLEAR: begin
                cpu_clear_d = 1'b1;
                busy_d      = 1'b1;
            end
            ST_RUN: begin
                cpu_run_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_ERROR: begin
                error_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {ADDR_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_data_q  <= {DATA_W{1'b0}};
            in_ready_q  <= 1'b0;
            cpu_clear_q <= 1'b0;
            cpu_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            in_ready_q  <= in_ready_d;
            cpu_clear_q <= cpu_clear_d;
            cpu_run_q   <= cpu_run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign cpu_clear    = cpu_clear_q;
    assign cpu_run      = cpu_run_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_sap_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_sap_ram_loader
// Self-checking bench for sap_ram_loader. Each load is described as a list of
// 16 program bytes plus a checksum byte; the expected RAM writes are simply
// (index, byte) pairs and the expected outcome is pass iff the byte sum plus
// checksum is 0 mod 256. A monitor records every observed write and counts
// cpu_clear / cpu_run cycles for comparison with that description.
// ---------------------------------------------------------------------------
module tb_sap_ram_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic cpu_halt;
    logic cpu_clear;
    logic cpu_run;
    logic busy;
    logic done;
    logic error;

    sap_ram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sap_ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cpu_halt  (cpu_halt),
        .bus       (bus),
        .cpu_clear (cpu_clear),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed writes {addr, data} and control-cycle counts (monitor-owned).
    logic [11:0] obs_w[$];
    int          n_clr = 0;
    int          n_run = 0;

    // Expected writes (stimulus-owned) and index of first unverified entry.
    logic [11:0] exp_w[$];
    int          vidx = 0;

    logic [7:0]  seq[DEPTH];

    // Record RAM writes and control cycles away from the active edge.
    always @(negedge clock) begin
        if (bus.ram_we === 1'b1) obs_w.push_back({bus.ram_addr, bus.ram_data});
        if (cpu_clear === 1'b1) n_clr <= n_clr + 1;
        if (cpu_run === 1'b1) n_run <= n_run + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic verify_writes(input string tag);
        check_eq({tag, "_wr_count"}, obs_w.size(), exp_w.size());
        for (int i = vidx; i < exp_w.size(); i++) begin
            check_eq({tag, "_wr"}, (i < obs_w.size()) ? {20'd0, obs_w[i]} : 32'hFFFF_FFFF,
                     {20'd0, exp_w[i]});
        end
        vidx = exp_w.size();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, {bus.in_ready, bus.ram_we, cpu_clear, cpu_run, busy, done, error}, 7'd0);
        check_eq({tag, "_ram_bus"}, {bus.ram_addr, bus.ram_data}, 12'd0);
    endtask

    // Present one byte after 'gap' idle cycles; returns after its handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clock);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) check_eq("hs_timeout", 32'd1, 32'd0);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("load_entry", {bus.in_ready, busy, done, error}, 4'b1100);
    endtask

    function automatic int gap_for(input int mode, input int i);
        if (mode == 1) return (i == 7) ? 5 : 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    // mode: 0 back-to-back, 1 toggled valid + long gap, 2 random gaps,
    //       3 back-to-back with start/cpu_halt disturbances during LOAD.
    task automatic run_load(input logic [7:0] bytes[DEPTH], input logic [7:0] ck, input int mode);
        logic [7:0] sum;
        int         clr0;
        int         run0;
        bit         pass;
        sum = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_w.push_back({i[3:0], bytes[i]});
            sum = sum + bytes[i];
        end
        pass = ((sum + ck) == 8'd0);
        start_load();
        clr0 = n_clr;
        run0 = n_run;
        for (int i = 0; i < DEPTH; i++) begin
            if (mode == 3 && i == 4) begin
                start    = 1'b1;
                cpu_halt = 1'b1;
            end
            send_byte(bytes[i], gap_for(mode, i));
            start    = 1'b0;
            cpu_halt = 1'b0;
        end
        send_byte(ck, gap_for(mode, DEPTH));
        if (pass) begin
            check_eq("clear_cycle", {cpu_clear, cpu_run, busy, done, error}, 5'b10100);
            @(negedge clock);
            check_eq("run_entry", {cpu_clear, cpu_run, busy, done, error}, 5'b01000);
            repeat (3) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check_eq("run_ignores_start", {cpu_run, busy, bus.in_ready}, 3'b100);
            cpu_halt = 1'b1;
            @(negedge clock);
            cpu_halt = 1'b0;
            check_eq("halt_done", {cpu_run, done, error, busy}, 4'b0100);
            check_eq("clear_count", n_clr - clr0, 32'd1);
        end else begin
            check_eq("error_entry", {error, busy, cpu_clear, cpu_run, done}, 5'b10000);
            repeat (4) @(negedge clock);
            check_eq("error_sticky", {error, done}, 2'b10);
            check_eq("error_no_clear", n_clr - clr0, 32'd0);
            check_eq("error_no_run", n_run - run0, 32'd0);
        end
        check_eq("ram_hold", {bus.ram_we, bus.ram_addr, bus.ram_data}, {1'b0, 4'hF, bytes[DEPTH-1]});
        verify_writes("load");
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] ck;
        reset        = 1'b1;
        start        = 1'b0;
        cpu_halt     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_eq("idle_quiet", {bus.in_ready, busy, done, error}, 4'd0);

        for (int i = 0; i < DEPTH; i++) seq[i] = 8'(i);

        // Good checksum, then bad checksum, then reload with stalls from ERROR.
        run_load(seq, 8'h88, 0);
        run_load(seq, 8'h87, 0);
        run_load(seq, 8'h88, 1);

        // Reset after 5 accepted bytes, with a 6th byte offered at the reset edge.
        start_load();
        for (int i = 0; i < 5; i++) begin
            exp_w.push_back({i[3:0], seq[i]});
            send_byte(seq[i], 0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        reset        = 1'b1;
        start        = 1'b1;
        cpu_halt     = 1'b1;
        @(negedge clock);
        check_all_zero("midload_reset");
        reset        = 1'b0;
        start        = 1'b0;
        cpu_halt     = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("after_reset_idle", {bus.in_ready, bus.ram_we, busy}, 3'd0);
        verify_writes("midload");

        // Ignored start/cpu_halt during LOAD, then the all-0xFF wrap case.
        run_load(seq, 8'h88, 3);
        for (int i = 0; i < DEPTH; i++) seq[i] = 8'hFF;
        run_load(seq, 8'h10, 0);

        // Random programs with random stalls; roughly half carry a bad checksum.
        for (int r = 0; r < 6; r++) begin
            sum = 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                seq[i] = 8'($urandom);
                sum    = sum + seq[i];
            end
            ck = 8'd0 - sum;
            if ($urandom_range(0, 1) == 1) ck = ck ^ 8'($urandom_range(1, 255));
            run_load(seq, ck, 2);
        end

        repeat (3) @(negedge clock);
        verify_writes("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sap_ram_loader.md
SAP_RAM_LOADER -- requirements
Module: sap_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (DEPTH = 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word / input byte width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a program load.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid program byte.
REQ-007 SHALL have port in_data  input  DATA_W  program byte or checksum byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port cpu_halt  input  1  CPU controller has decoded HALT.
REQ-010 SHALL have port ram_we  output  1  RAM write strobe.
REQ-011 SHALL have port ram_addr  output  ADDR_W  RAM write address.
REQ-012 SHALL have port ram_data  output  DATA_W  RAM write data.
REQ-013 SHALL have port cpu_clear  output  1  one-cycle clear of CPU PC and ring counter.
REQ-014 SHALL have port cpu_run  output  1  CPU clock enable; CPU frozen when low.
REQ-015 SHALL have ports busy, done, error  output  1 each  status flags.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, CLEAR, RUN, DONE, ERROR.
REQ-017 Handshake SHALL occur only in a cycle with in_valid=1 and in_ready=1; in_ready=1 exactly in LOAD and CHECK, independent of in_valid.
REQ-018 IDLE, DONE, ERROR: start=1 SHALL go to LOAD next cycle with byte counter=0, checksum accumulator=0, error and done cleared.
REQ-019 start SHALL be ignored in LOAD, CHECK, CLEAR, RUN.
REQ-020 LOAD: each handshake SHALL, in the following cycle, drive ram_we=1, ram_addr=counter value at acceptance, ram_data=accepted byte (one write per byte, registered).
REQ-021 LOAD: each handshake SHALL increment counter and add byte to accumulator modulo 2**DATA_W; the DEPTH-th handshake SHALL move to CHECK.
REQ-022 CHECK: one handshake SHALL consume the checksum byte; no RAM write for it.
REQ-023 Checksum pass SHALL be (accumulator + checksum byte) mod 2**DATA_W == 0 -> CLEAR; else -> ERROR.
REQ-024 CLEAR SHALL last exactly one cycle with cpu_clear=1, cpu_run=0, then RUN.
REQ-025 RUN: cpu_run=1 each cycle; cpu_halt=1 SHALL move to DONE, cpu_run=0 from the next cycle.
REQ-026 cpu_halt SHALL be ignored outside RUN.
REQ-027 busy=1 in LOAD, CHECK, CLEAR; done=1 only in DONE; error=1 only in ERROR (sticky until start or reset).
REQ-028 ram_we SHALL be 0 in every cycle not immediately following a LOAD handshake; ram_addr/ram_data hold last value when ram_we=0.
REQ-029 Stalls (in_valid=0) SHALL not advance counter or accumulator, for any duration.

Reset
REQ-030 reset=1 SHALL, at the next edge, force IDLE, counter=0, accumulator=0, ram_addr=0, ram_data=0 and all outputs 0 (in_ready, ram_we, cpu_clear, cpu_run, busy, done, error).
REQ-031 reset SHALL override start, in_valid and cpu_halt in the same cycle; a handshake accepted in the cycle before reset SHALL NOT produce a write after reset.

Verification
REQ-032 Pass load: start, then bytes 0x00..0x0F back-to-back, checksum 0x88 -> 16 writes addr 0..15 data=addr, one cpu_clear cycle, then cpu_run=1; cpu_halt -> done=1, cpu_run=0.
REQ-033 Bad checksum: same bytes, checksum 0x87 -> error=1, cpu_clear and cpu_run never asserted; start then reloads from addr 0.
REQ-034 Stalls: in_valid toggled 1/0 every cycle plus 5-cycle gap at byte 7 -> identical writes to REQ-032, one per accepted byte.
REQ-035 Reset mid-load: reset after 5 accepted bytes -> IDLE, outputs 0, no further ram_we; fresh start writes from addr 0.
REQ-036 Ignored inputs: start during LOAD and RUN, cpu_halt during LOAD -> no state change; wrap case bytes all 0xFF, checksum 0x10 -> pass.
